bcd_pair_counter: RTL and testbench

Two-digit BCD up/down counter (00-99) that generates the left and right digit codes consumed by the downstream latched seven-segment display stage. It sits directly upstream of that stage. It paces counting with an internal prescaler, supports start/stop and a parallel load, and issues a one-cycle Latch_Enable strobe whenever the displayed value changes. The display stage uses that strobe to capture the new digits.

---
 rtl/bcd_pair_counter.sv | 143 ++++++++++++++
 tb/tb_bcd_pair_counter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter with prescaled stepping, load and
// a one-cycle latch strobe for the downstream seven-segment stage.
module bcd_pair_counter #(
  parameter int TICK_DIV = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Up_Down,
  input  logic       Load,
  input  logic [7:0] Load_Value,
  output logic [3:0] Digit_L,
  output logic [3:0] Digit_R,
  output logic       Latch_Enable,
  output logic       Carry,
  output logic       Load_Err,
  output logic       Running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [3:0]    dl_q, dl_d;
  logic [3:0]    dr_q, dr_d;
  logic          le_q, le_d;
  logic          carry_q, carry_d;
  logic          lerr_q, lerr_d;
  logic          run_q, run_d;

  logic load_ok;
  logic load_acc;
  logic load_rej;
  logic tick;
  logic step;
  logic wrap;

  // Next state: Stop beats Start when both arrive together
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (Start && !Stop) state_d = RUN;
      RUN:  if (Stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load qualification, prescaler and the step it produces
  always_comb begin
    load_ok  = (Load_Value[7:4] <= 4'd9) &&
               (Load_Value[3:0] <= 4'd9);
    load_acc = Load && load_ok;
    load_rej = Load && !load_ok;
    tick     = (state_q == RUN) && (ps_q == PS_LAST);
    step     = tick && !load_acc;
    ps_d     = ps_q;
    if (load_acc || (state_q == IDLE && state_d == RUN))
      ps_d = '0;
    else if (state_q == RUN)
      ps_d = tick ? '0 : ps_q + PW'(1);
  end

  // Digit arithmetic; accepted load overrides a coincident step
  always_comb begin
    dl_d = dl_q;
    dr_d = dr_q;
    wrap = 1'b0;
    if (load_acc) begin
      dl_d = Load_Value[7:4];
      dr_d = Load_Value[3:0];
    end else if (step && Up_Down) begin
      if (dr_q >= 4'd9) begin
        dr_d = 4'd0;
        if (dl_q >= 4'd9) begin
          dl_d = 4'd0;
          wrap = 1'b1;
        end else begin
          dl_d = dl_q + 4'd1;
        end
      end else begin
        dr_d = dr_q + 4'd1;
      end
    end else if (step) begin
      if (dr_q == 4'd0) begin
        dr_d = 4'd9;
        if (dl_q == 4'd0) begin
          dl_d = 4'd9;
          wrap = 1'b1;
        end else begin
          dl_d = dl_q - 4'd1;
        end
      end else begin
        dr_d = dr_q - 4'd1;
      end
    end
  end

  // Registered strobes and status
  always_comb begin
    le_d    = step || load_acc;
    carry_d = step && wrap;
    lerr_d  = load_rej;
    run_d   = (state_d == RUN);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ps_q    <= '0;
      dl_q    <= 4'd0;
      dr_q    <= 4'd0;
      le_q    <= 1'b0;
      carry_q <= 1'b0;
      lerr_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      dl_q    <= dl_d;
      dr_q    <= dr_d;
      le_q    <= le_d;
      carry_q <= carry_d;
      lerr_q  <= lerr_d;
      run_q   <= run_d;
    end
  end

  assign Digit_L      = dl_q;
  assign Digit_R      = dr_q;
  assign Latch_Enable = le_q;
  assign Carry        = carry_q;
  assign Load_Err     = lerr_q;
  assign Running      = run_q;

endmodule

// File: tb/tb_bcd_pair_counter.sv
// Scoreboard bench for bcd_pair_counter at TICK_DIV=4.
// Expected digit updates are queued at stimulus time, popped on strobe.
module tb_bcd_pair_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       Up_Down = 1'b1;
  logic       Load = 1'b0;
  logic [7:0] Load_Value = 8'h00;
  logic [3:0] Digit_L;
  logic [3:0] Digit_R;
  logic       Latch_Enable;
  logic       Carry;
  logic       Load_Err;
  logic       Running;

  typedef struct packed {
    logic [3:0] l;
    logic [3:0] r;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   mval = 0;

  bcd_pair_counter #(.TICK_DIV(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .Start        (Start),
    .Stop         (Stop),
    .Up_Down      (Up_Down),
    .Load         (Load),
    .Load_Value   (Load_Value),
    .Digit_L      (Digit_L),
    .Digit_R      (Digit_R),
    .Latch_Enable (Latch_Enable),
    .Carry        (Carry),
    .Load_Err     (Load_Err),
    .Running      (Running)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  // Model of one count step on the decimal value 0..99
  function automatic void push_step(input bit up);
    exp_t e;
    bit   c;
    c = 1'b0;
    if (up) begin
      if (mval == 99) begin mval = 0; c = 1'b1; end
      else mval = mval + 1;
    end else begin
      if (mval == 0) begin mval = 99; c = 1'b1; end
      else mval = mval - 1;
    end
    e.l = 4'(mval / 10);
    e.r = 4'(mval % 10);
    e.c = c;
    sb.push_back(e);
  endfunction

  function automatic void push_load(input int v);
    exp_t e;
    mval = v;
    e.l = 4'(v / 10);
    e.r = 4'(v % 10);
    e.c = 1'b0;
    sb.push_back(e);
  endfunction

  task automatic wait_le(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget && waited < 0; i++) begin
      tick();
      if (Latch_Enable === 1'b1) waited = i;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({Digit_L, Digit_R, Latch_Enable, Carry, Load_Err, Running}
        !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_hold: got %h%h le=%b c=%b err=%b run=%b, want all 0",
               Digit_L, Digit_R, Latch_Enable, Carry, Load_Err, Running);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({Digit_L, Digit_R, Latch_Enable, Carry, Load_Err, Running}
        !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_release: got %h%h le=%b c=%b err=%b run=%b, want all 0",
               Digit_L, Digit_R, Latch_Enable, Carry, Load_Err, Running);
    end
    Load_Value = 8'h37;
    Load = 1'b1;
    push_load(37);
    tick();
    Load = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({Latch_Enable, Digit_L, Digit_R} !== {1'b1, e.l, e.r}) begin
      n_fail++;
      $display("FAIL reset_load37: got le=%b %h%h, want le=1 %h%h",
               Latch_Enable, Digit_L, Digit_R, e.l, e.r);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({Digit_L, Digit_R, Latch_Enable, Running} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h%h le=%b run=%b, want 00 le=0 run=0",
               Digit_L, Digit_R, Latch_Enable, Running);
    end
    sb.delete();
    mval = 0;
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({Digit_L, Digit_R, Latch_Enable, Running} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_after: got %h%h le=%b run=%b, want idle 00",
               Digit_L, Digit_R, Latch_Enable, Running);
    end
  endtask

  task automatic test_count();
    exp_t e;
    int   w;
    Up_Down = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_checks++;
    if (Running !== 1'b1) begin
      n_fail++;
      $display("FAIL count_running: got %b, want 1", Running);
    end
    for (int k = 0; k < 2; k++) begin
      push_step(1'b1);
      wait_le(10, w);
      n_checks++;
      if (w != 4) begin
        n_fail++;
        $display("FAIL count_gap%0d: got %0d cycles, want 4", k, w);
      end
      e = sb.pop_front();
      n_checks++;
      if ({Digit_L, Digit_R, Carry} !== {e.l, e.r, e.c}) begin
        n_fail++;
        $display("FAIL count_step%0d: got %h%h c=%b, want %h%h c=%b",
                 k, Digit_L, Digit_R, Carry, e.l, e.r, e.c);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   w;
    Load_Value = 8'h98;
    Load = 1'b1;
    push_load(98);
    tick();
    Load = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({Latch_Enable, Digit_L, Digit_R} !== {1'b1, e.l, e.r}) begin
      n_fail++;
      $display("FAIL wrap_load: got le=%b %h%h, want le=1 %h%h",
               Latch_Enable, Digit_L, Digit_R, e.l, e.r);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) Up_Down = 1'b0;
      push_step(Up_Down);
      wait_le(10, w);
      e = sb.pop_front();
      n_checks++;
      if (w < 0 || {Digit_L, Digit_R, Carry} !== {e.l, e.r, e.c}) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %h%h c=%b wait=%0d, want %h%h c=%b",
                 k, Digit_L, Digit_R, Carry, w, e.l, e.r, e.c);
      end
      if (k > 0) begin
        tick();
        n_checks++;
        if (Carry !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_carry_pulse%0d: got %b, want 0", k, Carry);
        end
      end
    end
  endtask

  task automatic test_load_err();
    exp_t       e;
    logic [7:0] bad [2];
    bad[0] = 8'h5A;
    bad[1] = 8'hA5;
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    n_checks++;
    if (Running !== 1'b0) begin
      n_fail++;
      $display("FAIL err_stop: got run=%b, want 0", Running);
    end
    for (int k = 0; k < 2; k++) begin
      Load_Value = bad[k];
      Load = 1'b1;
      tick();
      Load = 1'b0;
      n_checks++;
      if ({Load_Err, Latch_Enable, Digit_L, Digit_R} !==
          {1'b1, 1'b0, 4'(mval / 10), 4'(mval % 10)}) begin
        n_fail++;
        $display("FAIL err_reject%0d: got err=%b le=%b %h%h, want err=1 le=0 %0d",
                 k, Load_Err, Latch_Enable, Digit_L, Digit_R, mval);
      end
      tick();
      n_checks++;
      if (Load_Err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse%0d: got %b, want 0", k, Load_Err);
      end
    end
    Load_Value = 8'h42;
    Load = 1'b1;
    push_load(42);
    tick();
    Load = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({Latch_Enable, Load_Err, Digit_L, Digit_R} !==
        {1'b1, 1'b0, e.l, e.r}) begin
      n_fail++;
      $display("FAIL err_good_load: got le=%b err=%b %h%h, want le=1 err=0 %h%h",
               Latch_Enable, Load_Err, Digit_L, Digit_R, e.l, e.r);
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    int   w;
    Load_Value = 8'h19;
    Load = 1'b1;
    push_load(19);
    tick();
    Load = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({Digit_L, Digit_R} !== {e.l, e.r}) begin
      n_fail++;
      $display("FAIL prio_load19: got %h%h, want %h%h",
               Digit_L, Digit_R, e.l, e.r);
    end
    Up_Down = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    Load_Value = 8'h42;
    Load = 1'b1;
    push_load(42);
    tick();
    Load = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({Latch_Enable, Carry, Digit_L, Digit_R} !==
        {1'b1, 1'b0, e.l, e.r}) begin
      n_fail++;
      $display("FAIL prio_collide: got le=%b c=%b %h%h, want le=1 c=0 %h%h",
               Latch_Enable, Carry, Digit_L, Digit_R, e.l, e.r);
    end
    push_step(1'b1);
    wait_le(10, w);
    e = sb.pop_front();
    n_checks++;
    if (w != 4 || {Digit_L, Digit_R} !== {e.l, e.r}) begin
      n_fail++;
      $display("FAIL prio_next: got %h%h after %0d, want %h%h after 4",
               Digit_L, Digit_R, w, e.l, e.r);
    end
  endtask

  task automatic test_stop_start();
    exp_t       e;
    int         w;
    int         le_seen;
    int         chg;
    logic [7:0] snap;
    Start = 1'b1;
    Stop = 1'b1;
    tick();
    Start = 1'b0;
    Stop = 1'b0;
    n_checks++;
    if (Running !== 1'b0) begin
      n_fail++;
      $display("FAIL ss_both: got run=%b, want 0", Running);
    end
    le_seen = 0;
    chg = 0;
    snap = {Digit_L, Digit_R};
    repeat (20) begin
      tick();
      if (Latch_Enable !== 1'b0) le_seen++;
      if ({Digit_L, Digit_R} !== snap) chg++;
    end
    n_checks++;
    if (le_seen != 0 || chg != 0) begin
      n_fail++;
      $display("FAIL ss_idle: got %0d strobes %0d changes, want 0 and 0",
               le_seen, chg);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_checks++;
    if (Running !== 1'b1) begin
      n_fail++;
      $display("FAIL ss_restart: got run=%b, want 1", Running);
    end
    push_step(1'b1);
    wait_le(10, w);
    e = sb.pop_front();
    n_checks++;
    if (w != 4 || {Digit_L, Digit_R} !== {e.l, e.r}) begin
      n_fail++;
      $display("FAIL ss_first_step: got %h%h after %0d, want %h%h after 4",
               Digit_L, Digit_R, w, e.l, e.r);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_load_err();
    test_load_priority();
    test_stop_start();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
